// File: rtl/anton_neopixel_rx.sv
// rtl/anton_neopixel_rx.sv - WS2812 one-wire receiver: pulse-width decode into 24-bit GRB pixels
// Resynchronises after power-up or a protocol error by waiting for a full reset gap.
module anton_neopixel_rx #(
    parameter int BIT_THRESHOLD = 6,
    parameter int MAX_HIGH      = 12,
    parameter int RESET_CYCLES  = 500,
    parameter int INDEX_W       = 8
) (
    input  logic               clk10mhz,
    input  logic               resetn,
    input  logic               neoIn,
    output logic [23:0]        pixelData,
    output logic [INDEX_W-1:0] pixelIndex,
    output logic               pixelValid,
    output logic               frameDone,
    output logic [INDEX_W-1:0] frameLength,
    output logic               errPulse,
    output logic               errPartial,
    output logic               busy
);

    localparam int HI_W = $clog2(MAX_HIGH + 2);
    localparam int LO_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HI_W-1:0] HI_SAT = HI_W'(MAX_HIGH + 1);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(MAX_HIGH);
    localparam logic [HI_W-1:0] HI_THR = HI_W'(BIT_THRESHOLD);
    localparam logic [LO_W-1:0] LO_SAT = LO_W'(RESET_CYCLES);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t state_q, state_d;

    logic               sync1_q, s_q, s_prev_q;
    logic [HI_W-1:0]    hi_cnt_q, hi_cnt_d;
    logic [LO_W-1:0]    lo_cnt_q, lo_cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic [INDEX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic               pix_ovf_q, pix_ovf_d;
    logic [23:0]        pixel_data_q, pixel_data_d;
    logic [INDEX_W-1:0] pixel_index_q, pixel_index_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [INDEX_W-1:0] frame_length_q, frame_length_d;
    logic               err_pulse_q, err_pulse_d;
    logic               err_partial_q, err_partial_d;
    logic               busy_q, busy_d;

    logic        rise;
    logic        new_bit;
    logic [23:0] shifted;

    assign rise    = s_q & ~s_prev_q;
    assign new_bit = (hi_cnt_q >= HI_THR);
    assign shifted = {shift_q[22:0], new_bit};

    always_ff @(posedge clk10mhz or negedge resetn) begin
        if (!resetn) begin
            sync1_q        <= 1'b0;
            s_q            <= 1'b0;
            s_prev_q       <= 1'b0;
            state_q        <= ST_SYNC;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            pix_cnt_q      <= '0;
            pix_ovf_q      <= 1'b0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_length_q <= '0;
            err_pulse_q    <= 1'b0;
            err_partial_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= neoIn;
            s_q            <= sync1_q;
            s_prev_q       <= s_q;
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            lo_cnt_q       <= lo_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            pix_cnt_q      <= pix_cnt_d;
            pix_ovf_q      <= pix_ovf_d;
            pixel_data_q   <= pixel_data_d;
            pixel_index_q  <= pixel_index_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_done_q   <= frame_done_d;
            frame_length_q <= frame_length_d;
            err_pulse_q    <= err_pulse_d;
            err_partial_q  <= err_partial_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        lo_cnt_d       = lo_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        pix_cnt_d      = pix_cnt_q;
        pix_ovf_d      = pix_ovf_q;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        frame_length_d = frame_length_q;
        err_pulse_d    = 1'b0;
        err_partial_d  = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            // Only a complete reset gap proves we are between frames.
            ST_SYNC: begin
                if (s_q) begin
                    lo_cnt_d = '0;
                end else if (lo_cnt_q == LO_SAT) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_cnt_d = lo_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    busy_d   = 1'b1;
                    hi_cnt_d = HI_W'(1);
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (hi_cnt_q > HI_MAX) begin
                    err_pulse_d = 1'b1;
                    bit_cnt_d   = '0;
                    busy_d      = 1'b0;
                    lo_cnt_d    = '0;
                    state_d     = ST_SYNC;
                end else if (s_q) begin
                    if (hi_cnt_q != HI_SAT) begin
                        hi_cnt_d = hi_cnt_q + 1'b1;
                    end
                end else begin
                    shift_d  = shifted;
                    lo_cnt_d = LO_W'(1);
                    state_d  = ST_LOW;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d     = '0;
                        pixel_data_d  = shifted;
                        pixel_index_d = pix_cnt_q;
                        pixel_valid_d = 1'b1;
                        pix_cnt_d     = pix_cnt_q + 1'b1;
                        if (pix_cnt_q == '1) begin
                            pix_ovf_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (lo_cnt_q == LO_SAT) begin
                    frame_done_d   = 1'b1;
                    frame_length_d = pix_ovf_q ? '1 : pix_cnt_q;
                    err_partial_d  = (bit_cnt_q != 5'd0);
                    pix_cnt_d      = '0;
                    pix_ovf_d      = 1'b0;
                    bit_cnt_d      = '0;
                    busy_d         = 1'b0;
                    state_d        = ST_IDLE;
                end else if (s_q) begin
                    hi_cnt_d = HI_W'(1);
                    state_d  = ST_HIGH;
                end else begin
                    lo_cnt_d = lo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign pixelData   = pixel_data_q;
    assign pixelIndex  = pixel_index_q;
    assign pixelValid  = pixel_valid_q;
    assign frameDone   = frame_done_q;
    assign frameLength = frame_length_q;
    assign errPulse    = err_pulse_q;
    assign errPartial  = err_partial_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// tb/tb_anton_neopixel_rx.sv - bench for anton_neopixel_rx
`timescale 1ns/1ps
module tb_anton_neopixel_rx;

    logic        clk10mhz = 1'b0;
    logic        resetn;
    logic        neoIn;
    logic [23:0] pixelData;
    logic [7:0]  pixelIndex;
    logic        pixelValid;
    logic        frameDone;
    logic [7:0]  frameLength;
    logic        errPulse;
    logic        errPartial;
    logic        busy;

    anton_neopixel_rx dut (
        .clk10mhz    (clk10mhz),
        .resetn      (resetn),
        .neoIn       (neoIn),
        .pixelData   (pixelData),
        .pixelIndex  (pixelIndex),
        .pixelValid  (pixelValid),
        .frameDone   (frameDone),
        .frameLength (frameLength),
        .errPulse    (errPulse),
        .errPartial  (errPartial),
        .busy        (busy)
    );

    always #50 clk10mhz = ~clk10mhz;

    typedef struct {
        logic [23:0] data;
        int          hi1;
        int          hi0;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic [7:0]  idx;
    } pix_t;

    typedef struct {
        logic [7:0] len;
        logic       partial;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    vec_t vecs[5];

    int total = 0;
    int bad   = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe from the DUT is matched against the queued expectation.
    always @(negedge clk10mhz) begin
        if (resetn === 1'b1) begin
            if (pixelValid) begin
                if (pix_q.size() == 0) begin
                    check("unexpected_pixel", {8'h0, pixelData}, 32'hFFFF_FFFF);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    check("pixel_data", {8'h0, pixelData}, {8'h0, e.data});
                    check("pixel_index", {24'h0, pixelIndex}, {24'h0, e.idx});
                end
            end
            if (frameDone) begin
                if (frm_q.size() == 0) begin
                    check("unexpected_frame_done", {24'h0, frameLength}, 32'hFFFF_FFFF);
                end else begin
                    frm_t f;
                    f = frm_q.pop_front();
                    check("frame_length", {24'h0, frameLength}, {24'h0, f.len});
                    check("err_partial_with_done", {31'h0, errPartial}, {31'h0, f.partial});
                    check("busy_drops_on_done", {31'h0, busy}, 32'h0);
                end
            end else if (errPartial) begin
                check("err_partial_without_done", 32'h1, 32'h0);
            end
            if (errPulse) err_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk10mhz);
        #1;
    endtask

    task automatic send_pulse(input int hi);
        int lo;
        lo = (hi >= 8) ? 4 : 12 - hi;
        neoIn = 1'b1;
        cycles(hi);
        neoIn = 1'b0;
        cycles(lo);
    endtask

    task automatic send_bits(input logic [23:0] data, input int nbits, input int hi1, input int hi0);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_pulse(data[i] ? hi1 : hi0);
        end
    endtask

    task automatic expect_pixel(input logic [23:0] d, input logic [7:0] idx);
        pix_t p;
        p.data = d;
        p.idx  = idx;
        pix_q.push_back(p);
    endtask

    task automatic expect_frame(input logic [7:0] len, input logic partial);
        frm_t f;
        f.len     = len;
        f.partial = partial;
        frm_q.push_back(f);
    endtask

    task automatic gap(input int n);
        neoIn = 1'b0;
        cycles(n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'hA53C0F, 8, 4};
        vecs[1] = '{24'hFFFFFF, 6, 5};
        vecs[2] = '{24'h000000, 12, 5};
        vecs[3] = '{24'h5A5A5A, 12, 4};
        vecs[4] = '{24'hC30F96, 7, 5};

        resetn = 1'b0;
        neoIn  = 1'b0;
        repeat (3) @(negedge clk10mhz);
        check("rst_pixel_data", {8'h0, pixelData}, 32'h0);
        check("rst_pixel_index", {24'h0, pixelIndex}, 32'h0);
        check("rst_strobes", {28'h0, pixelValid, frameDone, errPulse, errPartial}, 32'h0);
        check("rst_frame_length", {24'h0, frameLength}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk10mhz);
        #1 resetn = 1'b1;
        gap(600);

        // Single-pixel frames, including high times 5/6/12 at the decision boundaries
        for (int v = 0; v < 5; v++) begin
            expect_pixel(vecs[v].data, 8'd0);
            expect_frame(8'd1, 1'b0);
            send_bits(vecs[v].data, 24, vecs[v].hi1, vecs[v].hi0);
            check("busy_in_frame", {31'h0, busy}, 32'h1);
            gap(600);
            check("busy_after_frame", {31'h0, busy}, 32'h0);
        end

        // Three back-to-back pixels
        expect_pixel(24'hFF0000, 8'd0);
        expect_pixel(24'h00FF00, 8'd1);
        expect_pixel(24'h0000FF, 8'd2);
        expect_frame(8'd3, 1'b0);
        send_bits(24'hFF0000, 24, 8, 4);
        send_bits(24'h00FF00, 24, 8, 4);
        send_bits(24'h0000FF, 24, 8, 4);
        check("busy_three_px", {31'h0, busy}, 32'h1);
        gap(600);

        // Overlong pulse, then traffic without a gap is ignored
        send_bits(24'h5, 3, 8, 4);
        send_pulse(13);
        cycles(4);
        check("err_pulse_count", err_seen, 1);
        check("busy_after_err", {31'h0, busy}, 32'h0);
        gap(20);
        send_bits(24'h123456, 24, 8, 4);
        gap(600);
        expect_pixel(24'h3C3C3C, 8'd0);
        expect_frame(8'd1, 1'b0);
        send_bits(24'h3C3C3C, 24, 8, 4);
        gap(600);

        // Ten bits then the gap
        expect_frame(8'd0, 1'b1);
        send_bits(24'h2AA, 10, 8, 4);
        gap(600);

        // Stream begins mid-pixel right after reset
        resetn = 1'b0;
        cycles(2);
        resetn = 1'b1;
        send_bits(24'hABC, 12, 8, 4);
        send_bits(24'h0F0F0F, 24, 8, 4);
        check("busy_while_unsynced", {31'h0, busy}, 32'h0);
        gap(600);
        expect_pixel(24'h81C3E7, 8'd0);
        expect_frame(8'd1, 1'b0);
        send_bits(24'h81C3E7, 24, 8, 4);
        gap(600);

        // Reset mid-pixel discards the partial pixel silently
        send_bits(24'hFFF, 12, 8, 4);
        neoIn  = 1'b0;
        resetn = 1'b0;
        repeat (5) begin
            @(negedge clk10mhz);
            check("strobes_in_reset", {28'h0, pixelValid, frameDone, errPulse, errPartial}, 32'h0);
            check("busy_in_reset", {31'h0, busy}, 32'h0);
        end
        @(posedge clk10mhz);
        #1 resetn = 1'b1;
        gap(600);
        expect_pixel(24'h123456, 8'd0);
        expect_pixel(24'hFEDCBA, 8'd1);
        expect_frame(8'd2, 1'b0);
        send_bits(24'h123456, 24, 8, 4);
        send_bits(24'hFEDCBA, 24, 8, 4);
        gap(600);

        check("pixels_outstanding", pix_q.size(), 0);
        check("frames_outstanding", frm_q.size(), 0);
        check("err_pulse_final", err_seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
